sma_mc_v2: RTL and testbench
============================

// Module: sma_mc_v2
// PURPOSE
//  Multi-channel simple moving average (SMA) for the FOG/PIG rate path.
//  Runtime-selectable power-of-two window per block; each channel keeps its own running sum and sample history.
//  The delay line sits in one shared block RAM; only sums, pointers and fill counters live in registers.
//  Sits between the demodulator/integrator output and the rate/angle output formatter.
// PARAMETERS
//  DATA_W    32  signed sample width (input and output)
//  LOG2_MAX  15  log2 of the largest window (max N = 2**LOG2_MAX)
//  N_CH      2   number of channels sharing the block; CH_W = max(1,$clog2(N_CH))
// PORTS
//  i_clk            in   1         single clock; all logic rising-edge
//  i_rst_n          in   1         reset: synchronous, active-low
//  i_update_strobe  in   1         one-cycle sample-valid pulse
//  i_ch             in   CH_W      channel of the current sample; values >= N_CH are ignored (no update)
//  i_data           in   DATA_W    signed sample
//  i_window_sel     in   5         log2(N); 0 = bypass; values > LOG2_MAX clamp to LOG2_MAX
//  o_valid          out  1         one-cycle result pulse
//  o_ch             out  CH_W      channel of o_data
//  o_data           out  DATA_W    signed average
//  o_filled         out  1         o_ch's window holds >= N samples since last flush
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge): o_valid=0, o_ch=0, o_data=0, o_filled=0; all sums, pointers and fill counts cleared.
//   Pipeline cleared; window register set to 0. RAM is not cleared.
//  Window register: i_window_sel is sampled into r_sel every cycle (clamped). N = 1<<r_sel.
//  Flush: when the clamped i_window_sel differs from r_sel, flush in the same edge that loads r_sel.
//   Flush zeroes every channel's sum, ptr and fill count, and kills in-flight pipeline stages (their o_valid is suppressed).
//   A strobe in the flush cycle is accepted against the new, empty window.
//  Pipeline, latency 2 (strobe at edge k -> o_valid at edge k+2):
//   S0: RAM read addr = {ch, ptr[ch]}; ptr[ch] <= (ptr[ch]+1) & (N-1).
//   S1: old = (fill[ch] < N) ? 0 : ram_q.
//       sum[ch] <= sum[ch] + sext(data) - old.
//       RAM write at the S0 address; fill[ch] saturates at N.
//   S2: o_data = new_sum >>> r_sel (arithmetic shift, floor rounding); o_filled = (fill >= N).
//  Sum width: DATA_W+LOG2_MAX+1 bits, signed; cannot overflow; the output always fits DATA_W.
//  Throughput: one strobe per cycle, any channel order. Back-to-back same-channel strobes forward the S1 sum result
//   into the next S1 (no bubble).
//   For N=2 the RAM address reuse distance is 2; write in S1 precedes the read in S0, so no RAM forwarding is needed.
//  Bypass (r_sel=0): o_data = i_data registered with the same latency 2; o_filled=1.
//   RAM and sums are not touched.
//  Stale RAM content after a flush is never used: the fill gate substitutes 0 until N new samples have been written.
//  Reset mid-operation: takes effect at the next edge and drops all in-flight data; o_valid is low from the following cycle.
// STRUCTURE
//  Package sma_pkg:
//   - window-sel localparams SEL_1..SEL_32768 (0..15).
//   - function sum_w(DATA_W, LOG2_MAX).
//   - typedef for per-channel state {sum, ptr, fill}.
//  Sub-module sma_dly_ram: simple dual-port RAM.
//   - depth N_CH<<LOG2_MAX, width DATA_W, 1-cycle registered read.
//   - write-first is not required.
//  Top: window/flush control, per-channel register file, 3-stage pipeline, same-channel sum forwarding.
// TESTING
//  1) sel=2 (N=4), ch0 strobes 4,8,12,16,20, one per cycle.
//     -> o_data 1,3,6,10,14; o_filled 0,0,0,1,1; each o_valid 2 cycles after its strobe.
//  2) Interleave ch0=+100 and ch1=-100, sel=3, 16 strobes back-to-back.
//     -> channels independent; from the 8th sample per channel, ch0=100 and ch1=-100.
//  3) sel=1 steady on 1000; then sel=4 mid-stream with a strobe in the change cycle.
//     -> in-flight results suppressed; new window restarts; first output 1000>>>4=62, o_filled=0 until 16 samples.
//  4) sel=15, feed 32768 samples of 0x7FFFFFFF, then -0x80000000.
//     -> no overflow; o_data=0x7FFFFFFF when full; output ramps down monotonically.
//  5) sel=0 bypass, random data with random strobe gaps -> o_data equals i_data delayed 2 cycles; sums untouched.
//  6) Drop i_rst_n for 1 cycle mid-stream, also check i_ch=N_CH and i_window_sel=31.
//     -> all outputs 0 after reset; invalid channel produces no o_valid; sel clamps to 15.

Source files
------------

// File: rtl/sma_mc_v2_pkg.sv
// Shared window-select codes and width helpers for the multi-channel moving average.
package sma_mc_v2_pkg;

  localparam logic [4:0] SEL_1     = 5'd0;
  localparam logic [4:0] SEL_2     = 5'd1;
  localparam logic [4:0] SEL_4     = 5'd2;
  localparam logic [4:0] SEL_8     = 5'd3;
  localparam logic [4:0] SEL_16    = 5'd4;
  localparam logic [4:0] SEL_32    = 5'd5;
  localparam logic [4:0] SEL_64    = 5'd6;
  localparam logic [4:0] SEL_128   = 5'd7;
  localparam logic [4:0] SEL_256   = 5'd8;
  localparam logic [4:0] SEL_512   = 5'd9;
  localparam logic [4:0] SEL_1024  = 5'd10;
  localparam logic [4:0] SEL_2048  = 5'd11;
  localparam logic [4:0] SEL_4096  = 5'd12;
  localparam logic [4:0] SEL_8192  = 5'd13;
  localparam logic [4:0] SEL_16384 = 5'd14;
  localparam logic [4:0] SEL_32768 = 5'd15;

  // One guard bit over the worst-case sum of 2**log2_max full-scale samples.
  function automatic int sum_w(input int data_w, input int log2_max);
    return data_w + log2_max + 1;
  endfunction

endpackage

// File: rtl/sma_mc_v2_if.sv
// Sample-in / average-out bundle of the moving-average block.
interface sma_mc_v2_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic                     i_update_strobe;
  logic [CH_W-1:0]          i_ch;
  logic signed [DATA_W-1:0] i_data;
  logic [4:0]               i_window_sel;
  logic                     o_valid;
  logic [CH_W-1:0]          o_ch;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_filled;

  modport master (
    output i_update_strobe, i_ch, i_data, i_window_sel,
    input  o_valid, o_ch, o_data, o_filled
  );

  modport slave (
    input  i_update_strobe, i_ch, i_data, i_window_sel,
    output o_valid, o_ch, o_data, o_filled
  );
endinterface

// File: rtl/sma_mc_v2_dly_ram.sv
// Shared sample delay line: simple dual-port RAM with a registered read port.
module sma_dly_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 16,
  parameter int DEPTH  = 1 << AW
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end
endmodule

// File: rtl/sma_mc_v2.sv
// Multi-channel power-of-two moving average: per-channel sums/pointers in flops,
// sample history in one shared RAM, 2-cycle strobe-to-result latency.
module sma_mc_v2
  import sma_mc_v2_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LOG2_MAX = 15,
  parameter int N_CH     = 2
) (
  input logic        i_clk,
  input logic        i_rst_n,
  sma_mc_v2_if.slave bus
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int N_SLOT = 1 << CH_W;
  localparam int SUM_W  = sum_w(DATA_W, LOG2_MAX);
  localparam int SEL_W  = $clog2(LOG2_MAX + 1);
  localparam int PW     = LOG2_MAX;
  localparam int FW     = LOG2_MAX + 1;
  localparam int AW     = CH_W + PW;

  typedef struct packed {
    logic signed [SUM_W-1:0] sum;
    logic [PW-1:0]           ptr;
    logic [FW-1:0]           fill;
  } ch_state_t;

  ch_state_t st [N_SLOT];

  logic [SEL_W-1:0]         r_sel, sel_c;
  logic                     flush, accept, bypass_s0;
  logic [N_SLOT-1:0]        ch_ok;
  logic [FW-1:0]            n_s0, n_r;
  logic [PW-1:0]            ptr_s0, ptr_nxt;
  logic [AW-1:0]            addr_s0;
  logic                     s1_valid, s1_bypass;
  logic [CH_W-1:0]          s1_ch;
  logic signed [DATA_W-1:0] s1_data;
  logic [AW-1:0]            s1_addr;
  logic signed [DATA_W-1:0] ram_q;
  logic                     s1_full, s1_upd, s1_filled;
  logic [FW-1:0]            s1_fill_nxt;
  logic signed [SUM_W-1:0]  s1_old, s1_sum_nxt;
  logic signed [DATA_W-1:0] s1_avg;
  logic                     s2_valid, s2_filled;
  logic [CH_W-1:0]          s2_ch;
  logic signed [DATA_W-1:0] s2_data;

  for (genvar g = 0; g < N_SLOT; g++) begin : g_ch_ok
    assign ch_ok[g] = (g < N_CH);
  end

  always_comb begin
    if (bus.i_window_sel > 5'(LOG2_MAX)) sel_c = SEL_W'(LOG2_MAX);
    else                                 sel_c = SEL_W'(bus.i_window_sel);
  end

  // A strobe in the flush cycle already sees the new window with an empty history.
  assign flush     = (sel_c != r_sel);
  assign accept    = bus.i_update_strobe & ch_ok[bus.i_ch];
  assign bypass_s0 = (sel_c == SEL_W'(SEL_1));
  assign n_s0      = FW'(1) << sel_c;
  assign n_r       = FW'(1) << r_sel;
  assign ptr_s0    = flush ? '0 : st[bus.i_ch].ptr;
  assign ptr_nxt   = (ptr_s0 + PW'(1)) & PW'(n_s0 - FW'(1));
  assign addr_s0   = {bus.i_ch, ptr_s0};

  // Sums live in flops written at the S1 edge, so a same-channel strobe right
  // behind reads the updated sum/fill directly; no bubble or bypass mux needed.
  always_comb begin
    s1_full     = (st[s1_ch].fill >= n_r);
    s1_old      = s1_full ? SUM_W'(ram_q) : '0;
    s1_sum_nxt  = st[s1_ch].sum + SUM_W'(s1_data) - s1_old;
    s1_fill_nxt = s1_full ? st[s1_ch].fill : st[s1_ch].fill + FW'(1);
    s1_filled   = (s1_fill_nxt >= n_r);
    s1_avg      = DATA_W'(s1_sum_nxt >>> r_sel);
  end

  assign s1_upd = s1_valid & ~s1_bypass & ~flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel        <= '0;
      s1_valid     <= 1'b0;
      s1_bypass    <= 1'b0;
      s1_ch        <= '0;
      s1_data      <= '0;
      s1_addr      <= '0;
      s2_valid     <= 1'b0;
      s2_ch        <= '0;
      s2_data      <= '0;
      s2_filled    <= 1'b0;
      bus.o_valid  <= 1'b0;
      bus.o_ch     <= '0;
      bus.o_data   <= '0;
      bus.o_filled <= 1'b0;
      for (int i = 0; i < N_SLOT; i++) st[i] <= '0;
    end else begin
      r_sel     <= sel_c;
      s1_valid  <= accept;
      s1_bypass <= bypass_s0;
      s1_ch     <= bus.i_ch;
      s1_data   <= bus.i_data;
      s1_addr   <= addr_s0;
      s2_valid  <= s1_valid & ~flush;
      s2_ch     <= s1_ch;
      s2_data   <= s1_bypass ? s1_data : s1_avg;
      s2_filled <= s1_bypass | s1_filled;
      bus.o_valid <= s2_valid & ~flush;
      if (s2_valid & ~flush) begin
        bus.o_ch     <= s2_ch;
        bus.o_data   <= s2_data;
        bus.o_filled <= s2_filled;
      end
      if (flush) begin
        for (int i = 0; i < N_SLOT; i++) st[i] <= '0;
      end else if (s1_upd) begin
        st[s1_ch].sum  <= s1_sum_nxt;
        st[s1_ch].fill <= s1_fill_nxt;
      end
      if (accept & ~bypass_s0) st[bus.i_ch].ptr <= ptr_nxt;
    end
  end

  // N=2 reuses an address every 2 strobes; the S1 write lands before that S0 read.
  sma_dly_ram #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .DEPTH  (N_CH << LOG2_MAX)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (s1_upd),
    .i_waddr (s1_addr),
    .i_wdata (s1_data),
    .i_re    (accept & ~bypass_s0),
    .i_raddr (addr_s0),
    .o_rdata (ram_q)
  );
endmodule

// File: tb/tb_sma_mc_v2.sv
// Self-checking bench: windowed-history reference model plus directed and random stimulus.
module tb_sma_mc_v2;
  import sma_mc_v2_pkg::*;

  localparam int NCH  = 3;
  localparam int CHW  = 2;
  localparam int LMAX = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cur_sel;
  bit   was_rst;

  always #5 clk = ~clk;

  sma_mc_v2_if #(.DATA_W(32), .CH_W(CHW)) bus ();

  sma_mc_v2 #(.DATA_W(32), .LOG2_MAX(LMAX), .N_CH(NCH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct { int due; int ch; longint data; bit filled; } exp_t;
  typedef struct { int ch; longint data; bit filled; } obs_t;

  exp_t   expq [$];
  obs_t   obs  [$];
  longint hist [NCH][$];
  longint msum [NCH];
  int     msel;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: each channel keeps its last N samples since the last flush.
  always @(posedge clk) begin
    int sc;
    int c;
    longint d;
    cyc++;
    was_rst = 1'b0;
    if (!rst_n) begin
      expq.delete();
      for (int k = 0; k < NCH; k++) begin hist[k].delete(); msum[k] = 0; end
      msel = 0;
      was_rst = 1'b1;
    end else begin
      sc = (int'(bus.i_window_sel) > LMAX) ? LMAX : int'(bus.i_window_sel);
      if (sc != msel) begin
        expq.delete();
        for (int k = 0; k < NCH; k++) begin hist[k].delete(); msum[k] = 0; end
        msel = sc;
      end
      if (bus.i_update_strobe && int'(bus.i_ch) < NCH) begin
        c = int'(bus.i_ch);
        d = longint'(bus.i_data);
        if (msel == 0) begin
          expq.push_back('{due: cyc + 2, ch: c, data: d, filled: 1'b1});
        end else begin
          hist[c].push_back(d);
          msum[c] += d;
          if (hist[c].size() > (1 << msel)) msum[c] -= hist[c].pop_front();
          expq.push_back('{due: cyc + 2, ch: c, data: msum[c] >>> msel,
                           filled: (hist[c].size() == (1 << msel))});
        end
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (was_rst) begin
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_ch", bus.o_ch, 0);
      chk("rst_data", bus.o_data, 0);
      chk("rst_filled", bus.o_filled, 0);
    end else if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("valid", bus.o_valid, 1);
      chk("ch", bus.o_ch, e.ch);
      chk("data", bus.o_data, e.data);
      chk("filled", bus.o_filled, e.filled);
    end else begin
      chk("idle_valid", bus.o_valid, 0);
    end
    if (bus.o_valid) obs.push_back('{ch: int'(bus.o_ch), data: longint'(bus.o_data), filled: bus.o_filled});
  end

  task automatic drv(input bit stb, input int ch, input int data);
    @(negedge clk);
    bus.i_update_strobe = stb;
    bus.i_ch            = CHW'(ch);
    bus.i_data          = data;
    bus.i_window_sel    = 5'(cur_sel);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 0, 0);
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_update_strobe = 1'b1;
    bus.i_ch = '0;
    bus.i_data = 55;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_update_strobe = 1'b0;
  endtask

  initial begin
    int v;
    int first_byp;
    rst_n = 1'b0;
    cur_sel = 0;
    bus.i_update_strobe = 1'b0;
    bus.i_ch = '0;
    bus.i_data = '0;
    bus.i_window_sel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // N=4 ramp on ch0
    cur_sel = int'(SEL_4);
    idle(3);
    obs.delete();
    for (int i = 1; i <= 5; i++) drv(1'b1, 0, 4 * i);
    idle(4);
    chk("t1_count", obs.size(), 5);
    if (obs.size() == 5) begin
      chk("t1_d0", obs[0].data, 1);
      chk("t1_d1", obs[1].data, 3);
      chk("t1_d2", obs[2].data, 6);
      chk("t1_d3", obs[3].data, 10);
      chk("t1_d4", obs[4].data, 14);
      chk("t1_f2", obs[2].filled, 0);
      chk("t1_f3", obs[3].filled, 1);
    end

    // interleaved channels, N=8
    cur_sel = int'(SEL_8);
    idle(3);
    obs.delete();
    for (int i = 0; i < 16; i++) drv(1'b1, i % 2, (i % 2 == 0) ? 100 : -100);
    idle(4);
    chk("t2_count", obs.size(), 16);
    if (obs.size() == 16) begin
      chk("t2_ch1_first", obs[1].data, -13);
      chk("t2_ch1_f7", obs[13].filled, 0);
      chk("t2_ch0_last", obs[14].data, 100);
      chk("t2_ch1_last", obs[15].data, -100);
      chk("t2_ch1_lastf", obs[15].filled, 1);
    end

    // window change mid-stream with strobe in the change cycle
    cur_sel = int'(SEL_2);
    idle(3);
    for (int i = 0; i < 6; i++) drv(1'b1, 0, 1000);
    cur_sel = int'(SEL_16);
    drv(1'b1, 0, 1000);
    obs.delete();
    for (int i = 0; i < 16; i++) drv(1'b1, 0, 1000);
    idle(4);
    chk("t3_count", obs.size(), 17);
    if (obs.size() == 17) begin
      chk("t3_first", obs[0].data, 62);
      chk("t3_first_f", obs[0].filled, 0);
      chk("t3_f15", obs[14].filled, 0);
      chk("t3_f16", obs[15].filled, 1);
      chk("t3_d16", obs[15].data, 1000);
    end

    // full-scale at the largest window, then ramp down; sel=31 must clamp (no flush)
    cur_sel = int'(SEL_32768);
    idle(3);
    obs.delete();
    for (int i = 0; i < 32768; i++) drv(1'b1, 0, 32'h7FFF_FFFF);
    v = 32'h8000_0000;
    for (int i = 0; i < 500; i++) drv(1'b1, 0, v);
    cur_sel = 31;
    for (int i = 0; i < 500; i++) drv(1'b1, 0, v);
    idle(4);
    chk("t4_count", obs.size(), 33768);
    if (obs.size() == 33768) begin
      chk("t4_pre_full_f", obs[32766].filled, 0);
      chk("t4_full", obs[32767].data, 64'sh7FFF_FFFF);
      chk("t4_full_f", obs[32767].filled, 1);
      chk("t4_ramp0", obs[32768].data, 2147352575);
      for (int i = 32769; i < 33768; i++) chk("t4_mono", obs[i].data <= obs[i - 1].data, 1);
    end

    // bypass with random gaps
    cur_sel = int'(SEL_1);
    idle(3);
    obs.delete();
    first_byp = int'($urandom);
    drv(1'b1, 1, first_byp);
    for (int i = 0; i < 200; i++) drv($urandom_range(0, 2) != 0, $urandom_range(0, 2), int'($urandom));
    idle(4);
    chk("t5_first", obs[0].data, longint'(first_byp));
    chk("t5_first_f", obs[0].filled, 1);

    // invalid channel and mid-stream reset
    cur_sel = int'(SEL_4);
    idle(3);
    obs.delete();
    repeat (3) drv(1'b1, 3, 77);
    idle(4);
    chk("t6_badch", obs.size(), 0);
    for (int i = 0; i < 6; i++) drv(1'b1, i % 3, 500 + i);
    rst_cycle();
    idle(6);

    // random soak
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        cur_sel = $urandom_range(0, 7);
        if (cur_sel == 7) cur_sel = 31;
      end
      if ($urandom_range(0, 599) == 0) rst_cycle();
      else drv($urandom_range(0, 3) != 0, $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
